// File: rtl/first_trial_counter_pkg.sv
// Shared defaults and sizing helper for the first_trial heartbeat counter.
package first_trial_pkg;

  localparam int FT_COUNT_WIDTH = 32;
  localparam int FT_HALF_PERIOD = 4;

  // Prescaler width: ceil(log2(hp)), but never narrower than one bit.
  function automatic int ft_presc_width(input int hp);
    return (hp <= 2) ? 1 : $clog2(hp);
  endfunction

endpackage

// File: rtl/first_trial_counter_if.sv
// Output bundle of the heartbeat counter: cycle count and divided square wave.
interface first_trial_counter_if
  import first_trial_pkg::*;
#(
  parameter int WIDTH = FT_COUNT_WIDTH
);

  logic             y;
  logic [WIDTH-1:0] count;

  modport master (output y, output count);
  modport slave  (input  y, input  count);

endinterface

// File: rtl/first_trial_counter_prescaler.sv
// Divides the clock by HALF_PERIOD, producing a one-cycle tick per period.
module first_trial_prescaler
  import first_trial_pkg::*;
#(
  parameter int HALF_PERIOD = FT_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int              PW   = ft_presc_width(HALF_PERIOD);
  localparam logic [PW-1:0]   LAST = PW'(HALF_PERIOD - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_c;

  always_comb begin
    tick_c  = (presc_q == LAST);
    presc_d = tick_c ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = tick_c;

endmodule

// File: rtl/first_trial_counter.sv
// Free-running cycle counter with a square-wave heartbeat of period 2*HALF_PERIOD.
module first_trial_counter
  import first_trial_pkg::*;
#(
  parameter int WIDTH       = FT_COUNT_WIDTH,
  parameter int HALF_PERIOD = FT_HALF_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst,
  first_trial_counter_if.master out_if
);

  if (WIDTH < 2) begin : g_bad_width
    $error("first_trial_counter: WIDTH must be >= 2");
  end
  if (HALF_PERIOD < 1 ||
      (WIDTH < 32 && 64'(HALF_PERIOD) >= (64'd1 << WIDTH))) begin : g_bad_half
    $error("first_trial_counter: HALF_PERIOD must satisfy 1 <= HALF_PERIOD < 2**WIDTH");
  end

  logic             tick;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             y_q;
  logic             y_d;

  // Prescaler runs on its own so a count wrap never disturbs the y phase.
  first_trial_prescaler #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    count_d = count_q + 1'b1;
    y_d     = y_q ^ tick;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      y_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      y_q     <= y_d;
    end
  end

  assign out_if.count = count_q;
  assign out_if.y     = y_q;

endmodule

// File: tb/tb_first_trial_counter.sv
// Scoreboard bench: four counter configurations driven by a shared clock/reset.
module tb_first_trial_counter;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  first_trial_counter_if #(.WIDTH(32)) if_a ();
  first_trial_counter_if #(.WIDTH(4))  if_b ();
  first_trial_counter_if #(.WIDTH(32)) if_c ();
  first_trial_counter_if #(.WIDTH(32)) if_d ();

  first_trial_counter #(.WIDTH(32), .HALF_PERIOD(4)) u_dut_a (.clk(clk), .rst(rst), .out_if(if_a));
  first_trial_counter #(.WIDTH(4),  .HALF_PERIOD(4)) u_dut_b (.clk(clk), .rst(rst), .out_if(if_b));
  first_trial_counter #(.WIDTH(32), .HALF_PERIOD(1)) u_dut_c (.clk(clk), .rst(rst), .out_if(if_c));
  first_trial_counter #(.WIDTH(32), .HALF_PERIOD(3)) u_dut_d (.clk(clk), .rst(rst), .out_if(if_d));

  typedef struct {
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    logic        y_hp4;
    logic        y_hp1;
    logic        y_hp3;
  } exp_t;

  exp_t exp_q[$];
  int   k_model;
  int   n_vec;
  int   n_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one edge: predict outputs from the cycle index since last reset.
  task automatic step(input logic r);
    exp_t e;
    rst = r;
    k_model = r ? k_model + 1 : 0;
    e.cnt32 = 32'(k_model);
    e.cnt4  = 4'(k_model);
    e.y_hp4 = ((k_model / 4) % 2) == 1;
    e.y_hp1 = (k_model % 2) == 1;
    e.y_hp3 = ((k_model / 3) % 2) == 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("a_count", if_a.count, e.cnt32);
      chk("a_y",     32'(if_a.y), 32'(e.y_hp4));
      chk("b_count", 32'(if_b.count), 32'(e.cnt4));
      chk("b_y",     32'(if_b.y), 32'(e.y_hp4));
      chk("c_count", if_c.count, e.cnt32);
      chk("c_y",     32'(if_c.y), 32'(e.y_hp1));
      chk("d_count", if_d.count, e.cnt32);
      chk("d_y",     32'(if_d.y), 32'(e.y_hp3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    k_model = 0;
    rst     = 1'b0;
    @(negedge clk);

    repeat (3)  step(1'b0);
    repeat (20) step(1'b1);
    step(1'b0);
    repeat (6)  step(1'b1);
    step(1'b0);
    repeat (10) step(1'b1);
    step(1'b0);
    repeat (40) step(1'b1);
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 9) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
